// File: rtl/fir_param_if.sv
// Bus bundle for fir_param: control, sample stream, coefficient port and result.
interface fir_param_if #(
  parameter int unsigned DW   = 4,
  parameter int unsigned CW   = 4,
  parameter int unsigned TAPS = 3
);
  localparam int unsigned OW = DW + CW + $clog2(TAPS);
  localparam int unsigned IW = $clog2(TAPS);

  logic          start;
  logic          halt;
  logic          in_valid;
  logic [DW-1:0] in;
  logic          coef_we;
  logic [IW-1:0] coef_idx;
  logic [CW-1:0] coef_data;
  logic [OW-1:0] out;
  logic          out_valid;
  logic          busy;
  logic          done;

  modport master (
    output start, halt, in_valid, in, coef_we, coef_idx, coef_data,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, halt, in_valid, in, coef_we, coef_idx, coef_data,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/fir_param.sv
// Run-controlled unsigned FIR filter with writable coefficients and a zero-fill tail drain.
module fir_param #(
  parameter int unsigned DW   = 4,
  parameter int unsigned CW   = 4,
  parameter int unsigned TAPS = 3
) (
  input  logic        clk,
  input  logic        rst,
  fir_param_if.slave  bus
);
  localparam int unsigned OW = DW + CW + $clog2(TAPS);
  localparam int unsigned IW = $clog2(TAPS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q, state_n;
  logic [DW-1:0] x_q [TAPS];
  logic [DW-1:0] x_n [TAPS];
  logic [CW-1:0] coef_q [TAPS];
  logic [IW-1:0] cnt_q, cnt_n;
  logic [OW-1:0] out_q;
  logic          out_valid_q, busy_q, done_q;

  logic          shift_c;
  logic          clear_c;
  logic [DW-1:0] shift_val_c;
  logic          out_valid_c;
  logic          coef_wr_c;
  logic [OW-1:0] y_c;

  // Next state, delay-line update and strobes
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    shift_c     = 1'b0;
    clear_c     = 1'b0;
    shift_val_c = '0;
    out_valid_c = 1'b0;
    coef_wr_c   = 1'b0;
    case (state_q)
      IDLE: begin
        coef_wr_c = bus.coef_we && (32'(bus.coef_idx) < TAPS);
        if (bus.start) begin
          state_n = RUN;
          clear_c = 1'b1;
        end
      end
      RUN: begin
        cnt_n = '0;
        if (bus.in_valid) begin
          shift_c     = 1'b1;
          shift_val_c = bus.in;
          out_valid_c = 1'b1;
        end
        if (bus.halt) state_n = DRAIN;
      end
      DRAIN: begin
        shift_c     = 1'b1;
        out_valid_c = 1'b1;
        cnt_n       = cnt_q + IW'(1);
        if (cnt_q == IW'(TAPS - 2)) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    for (int k = 0; k < TAPS; k++) x_n[k] = x_q[k];
    if (clear_c) begin
      for (int k = 0; k < TAPS; k++) x_n[k] = '0;
    end else if (shift_c) begin
      x_n[0] = shift_val_c;
      for (int k = 1; k < TAPS; k++) x_n[k] = x_q[k-1];
    end
  end

  // Full-precision dot product over the post-shift delay line
  always_comb begin
    y_c = '0;
    for (int k = 0; k < TAPS; k++) y_c = y_c + OW'(coef_q[k]) * OW'(x_n[k]);
  end

  // State, delay line, coefficients and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= CW'(k + 3);
      end
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      out_valid_q <= out_valid_c;
      busy_q      <= (state_n == RUN) || (state_n == DRAIN);
      done_q      <= (state_n == DONE);
      if (out_valid_c) out_q <= y_c;
      for (int k = 0; k < TAPS; k++) x_q[k] <= x_n[k];
      if (coef_wr_c) coef_q[bus.coef_idx] <= bus.coef_data;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_fir_param.sv
// Directed bench for fir_param with default parameters (DW=CW=4, TAPS=3).
module tb_fir_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  fir_param_if #(.DW(4), .CW(4), .TAPS(3)) bus ();

  fir_param #(.DW(4), .CW(4), .TAPS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count one comparison and report a mismatch
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; values read afterwards are post-edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.halt = 0; bus.in_valid = 0; bus.in = 0;
    bus.coef_we = 0; bus.coef_idx = 0; bus.coef_data = 0;
  endtask

  // Unit impulse with halt on the sample cycle; optional coef write attempt while running
  task automatic run_impulse(input string tag, input int e0, input int e1, input int e2,
                             input bit poke);
    bus.start = 1; step(); bus.start = 0;
    check({tag, ".busy_run"}, int'(bus.busy), 1);
    if (poke) begin
      bus.coef_we = 1; bus.coef_idx = 0; bus.coef_data = 9;
      step();
      bus.coef_we = 0;
      check({tag, ".poke_nv"}, int'(bus.out_valid), 0);
    end
    bus.in = 1; bus.in_valid = 1; bus.halt = 1;
    step();
    bus.in = 0; bus.in_valid = 0; bus.halt = 0;
    check({tag, ".y0"}, int'(bus.out), e0);
    check({tag, ".v0"}, int'(bus.out_valid), 1);
    step();
    check({tag, ".y1"}, int'(bus.out), e1);
    check({tag, ".v1"}, int'(bus.out_valid), 1);
    check({tag, ".busy_drain"}, int'(bus.busy), 1);
    step();
    check({tag, ".y2"}, int'(bus.out), e2);
    check({tag, ".v2"}, int'(bus.out_valid), 1);
    check({tag, ".done"}, int'(bus.done), 1);
    check({tag, ".busy_done"}, int'(bus.busy), 0);
    step();
    check({tag, ".done_off"}, int'(bus.done), 0);
    check({tag, ".v_off"}, int'(bus.out_valid), 0);
    check({tag, ".hold"}, int'(bus.out), e2);
  endtask

  task automatic write_coef(input int idx, input int val);
    bus.coef_we = 1; bus.coef_idx = 2'(idx); bus.coef_data = 4'(val);
    step();
    bus.coef_we = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1; step(); step(); rst = 0;
    check("rst.out", int'(bus.out), 0);
    check("rst.valid", int'(bus.out_valid), 0);
    check("rst.busy", int'(bus.busy), 0);
    check("rst.done", int'(bus.done), 0);

    run_impulse("impulse", 3, 4, 5, 0);

    // Idle-state write of c[1]; out-of-range index must not disturb anything
    write_coef(1, 0);
    write_coef(3, 7);
    run_impulse("coefwr", 3, 0, 5, 0);

    // Write attempt during RUN is dropped
    run_impulse("wrign", 3, 0, 5, 1);

    // Mid-run reset
    bus.start = 1; step(); bus.start = 0;
    bus.in = 1; bus.in_valid = 1; step(); bus.in_valid = 0; bus.in = 0;
    check("mrst.pre", int'(bus.out), 3);
    rst = 1; step(); rst = 0;
    check("mrst.out", int'(bus.out), 0);
    check("mrst.busy", int'(bus.busy), 0);
    check("mrst.valid", int'(bus.out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1; bus.in = 5; bus.halt = 1;
      step();
      check("mrst.nodone", int'(bus.done), 0);
      check("mrst.idle_v", int'(bus.out_valid), 0);
    end
    idle_inputs();
    run_impulse("mrst.impulse", 3, 4, 5, 0);

    // Gapped input: samples 2, 1, 0 with idle cycles between
    bus.start = 1; step(); bus.start = 0;
    bus.in = 2; bus.in_valid = 1; step(); bus.in_valid = 0;
    check("gap.y0", int'(bus.out), 6);
    check("gap.v0", int'(bus.out_valid), 1);
    step();
    check("gap.nv0", int'(bus.out_valid), 0);
    check("gap.hold0", int'(bus.out), 6);
    bus.in = 1; bus.in_valid = 1; step(); bus.in_valid = 0;
    check("gap.y1", int'(bus.out), 11);
    check("gap.v1", int'(bus.out_valid), 1);
    step(); step();
    check("gap.nv1", int'(bus.out_valid), 0);
    check("gap.hold1", int'(bus.out), 11);
    bus.in = 0; bus.in_valid = 1; step(); bus.in_valid = 0;
    check("gap.y2", int'(bus.out), 14);
    bus.halt = 1; step(); bus.halt = 0;
    check("gap.halt_nv", int'(bus.out_valid), 0);
    check("gap.halt_hold", int'(bus.out), 14);
    step();
    check("gap.d0", int'(bus.out), 5);
    check("gap.dv0", int'(bus.out_valid), 1);
    step();
    check("gap.d1", int'(bus.out), 0);
    check("gap.done", int'(bus.done), 1);
    step();
    check("gap.idle", int'(bus.busy), 0);

    // Full scale: all coefficients 15, last write shares the cycle with start
    write_coef(0, 15);
    write_coef(1, 15);
    bus.coef_we = 1; bus.coef_idx = 2; bus.coef_data = 15; bus.start = 1;
    step();
    bus.coef_we = 0; bus.start = 0;
    check("fs.busy", int'(bus.busy), 1);
    bus.in = 15; bus.in_valid = 1;
    step();
    check("fs.y0", int'(bus.out), 225);
    step();
    check("fs.y1", int'(bus.out), 450);
    step();
    check("fs.y2", int'(bus.out), 675);
    bus.halt = 1; step(); bus.halt = 0; bus.in_valid = 0;
    check("fs.y3", int'(bus.out), 675);
    step();
    check("fs.d0", int'(bus.out), 450);
    step();
    check("fs.d1", int'(bus.out), 225);
    check("fs.done", int'(bus.done), 1);
    step();
    check("fs.done_off", int'(bus.done), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
